calc_seq: RTL and testbench

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_seq.sv | 134 +++++++++++++
 tb/tb_calc_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// calc_seq: sequencer for an external combinational calculator with accumulator.
// Optional saturation of overflowed results when CALC_SEQ_SAT_EN is defined.
module calc_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_use_acc,
    input  logic         in_acc_wr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         out_ovf,
    output logic [2:0]   calc_op,
    output logic [W-1:0] calc_a,
    output logic [W-1:0] calc_b,
    input  logic [W-1:0] calc_r,
    input  logic         calc_ovf,
    output logic [W-1:0] acc,
    output logic         sticky_ovf,
    input  logic         clr_sticky
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         acc_wr_q, acc_wr_d;
    logic [W-1:0] out_r_q, out_r_d;
    logic         out_ovf_q, out_ovf_d;
    logic [W-1:0] acc_q, acc_d;
    logic         sticky_q, sticky_d;
    logic         sticky_set;
    logic [W-1:0] res;

`ifdef CALC_SEQ_SAT_EN
    // Wrapped sign bit set means the true result overflowed upward.
    always_comb begin
        res = calc_r;
        if (calc_ovf) begin
            res = calc_r[W-1] ? {1'b0, {(W-1){1'b1}}}
                              : {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    assign res = calc_r;
`endif

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == RESP) && !rst;
    assign out_r      = out_r_q;
    assign out_ovf    = out_ovf_q;
    assign calc_op    = op_q;
    assign calc_a     = a_q;
    assign calc_b     = b_q;
    assign acc        = acc_q;
    assign sticky_ovf = sticky_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_wr_d   = acc_wr_q;
        out_r_d    = out_r_q;
        out_ovf_d  = out_ovf_q;
        acc_d      = acc_q;
        sticky_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = in_op;
                    a_d      = in_use_acc ? acc_q : in_a;
                    b_d      = in_b;
                    acc_wr_d = in_acc_wr;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                out_r_d    = res;
                out_ovf_d  = calc_ovf;
                sticky_set = calc_ovf;
                if (acc_wr_q) begin
                    acc_d = res;
                end
                state_d = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Setting wins over a coincident clear.
        sticky_d = (sticky_q & ~clr_sticky) | sticky_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_wr_q  <= 1'b0;
            out_r_q   <= '0;
            out_ovf_q <= 1'b0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_wr_q  <= acc_wr_d;
            out_r_q   <= out_r_d;
            out_ovf_q <= out_ovf_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a behavioural model of the downstream calculator.
// Expected values depend on whether CALC_SEQ_SAT_EN is defined.
module tb_calc_seq;

`ifdef CALC_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_use_acc;
    logic        in_acc_wr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic        out_ovf;
    logic [2:0]  calc_op;
    logic [15:0] calc_a;
    logic [15:0] calc_b;
    logic [15:0] calc_r;
    logic        calc_ovf;
    logic [15:0] acc;
    logic        sticky_ovf;
    logic        clr_sticky;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_seq #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_use_acc(in_use_acc),
        .in_acc_wr (in_acc_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_ovf   (out_ovf),
        .calc_op   (calc_op),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_r    (calc_r),
        .calc_ovf  (calc_ovf),
        .acc       (acc),
        .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky)
    );

    function automatic logic [16:0] f_add(logic [15:0] x, logic [15:0] y);
        logic [15:0] s;
        s = x + y;
        return {(x[15] == y[15]) && (s[15] != x[15]), s};
    endfunction

    function automatic logic [16:0] f_sub(logic [15:0] x, logic [15:0] y);
        logic [15:0] d;
        d = x - y;
        return {(x[15] != y[15]) && (d[15] != x[15]), d};
    endfunction

    function automatic logic [16:0] f_abs(logic [15:0] x);
        logic [15:0] m;
        m = x[15] ? (16'h0 - x) : x;
        return {x == 16'h8000, m};
    endfunction

    function automatic logic [16:0] calc_model(
        logic [2:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            3'b000:         return f_add(a, b);
            3'b001:         return f_sub(a, b);
            3'b010, 3'b011: return f_abs(b);
            3'b100:         return f_add(b, a);
            3'b101:         return f_sub(b, a);
            default:        return f_abs(a);
        endcase
    endfunction

    always_comb {calc_ovf, calc_r} = calc_model(calc_op, calc_a, calc_b);

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a command for one edge; returns at the negedge inside EXEC.
    task automatic send(logic [2:0] op, logic [15:0] a, logic [15:0] b,
                        logic ua, logic aw);
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = ua;
        in_acc_wr  = aw;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 3'b0;
        in_a       = 16'h0;
        in_b       = 16'h0;
        in_use_acc = 1'b0;
        in_acc_wr  = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_r", out_r, 16'h0);
        chk("rst_acc", acc, 16'h0);
        chk("rst_sticky", 16'(sticky_ovf), 16'h0);
        chk("rst_calc_a", calc_a, 16'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 16'(in_ready), 16'h1);
        @(negedge clk);

        // 5 + 7
        send(3'b000, 16'd5, 16'd7, 1'b0, 1'b0);
        chk("c1_exec_valid", 16'(out_valid), 16'h0);
        chk("c1_exec_ready", 16'(in_ready), 16'h0);
        chk("c1_calc_a", calc_a, 16'd5);
        chk("c1_calc_b", calc_b, 16'd7);
        @(negedge clk);
        chk("c1_resp_valid", 16'(out_valid), 16'h1);
        chk("c1_resp_ready", 16'(in_ready), 16'h0);
        chk("c1_out_r", out_r, 16'd12);
        chk("c1_out_ovf", 16'(out_ovf), 16'h0);
        @(negedge clk);
        chk("c1_idle_ready", 16'(in_ready), 16'h1);
        chk("c1_idle_valid", 16'(out_valid), 16'h0);
        chk("c1_sticky", 16'(sticky_ovf), 16'h0);

        // 0x7FFF - (-1) overflows
        send(3'b001, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("c2_out_ovf", 16'(out_ovf), 16'h1);
        chk("c2_out_r", out_r, SAT ? 16'h7FFF : 16'h8000);
        chk("c2_sticky", 16'(sticky_ovf), 16'h1);
        chk("c2_acc", acc, 16'h0);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("c2_sticky_clr", 16'(sticky_ovf), 16'h0);

        // |0x8000| written to acc
        send(3'b110, 16'h8000, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("c3_out_ovf", 16'(out_ovf), 16'h1);
        chk("c3_out_r", out_r, SAT ? 16'h7FFF : 16'h8000);
        chk("c3_acc", acc, SAT ? 16'h7FFF : 16'h8000);
        @(negedge clk);

        // acc + 1, in_a must be ignored
        send(3'b000, 16'h1234, 16'h0001, 1'b1, 1'b0);
        chk("c4_calc_a", calc_a, SAT ? 16'h7FFF : 16'h8000);
        @(negedge clk);
        chk("c4_out_r", out_r, SAT ? 16'h7FFF : 16'h8001);
        chk("c4_out_ovf", 16'(out_ovf), SAT ? 16'h1 : 16'h0);
        chk("c4_acc_hold", acc, SAT ? 16'h7FFF : 16'h8000);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;

        // B + A with output backpressure
        out_ready = 1'b0;
        send(3'b100, 16'd3, 16'd10, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_op    = 3'b001;
            in_a     = 16'h1111 + 16'(i);
            in_b     = 16'h2222;
            chk("c5_hold_valid", 16'(out_valid), 16'h1);
            chk("c5_hold_r", out_r, 16'd13);
            chk("c5_hold_ready", 16'(in_ready), 16'h0);
            @(negedge clk);
        end
        chk("c5_calc_a", calc_a, 16'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("c5_idle_ready", 16'(in_ready), 16'h1);
        chk("c5_idle_valid", 16'(out_valid), 16'h0);

        // Remaining opcodes
        send(3'b101, 16'd2, 16'd9, 1'b0, 1'b0);
        @(negedge clk);
        chk("c6_b_minus_a", out_r, 16'd7);
        @(negedge clk);
        send(3'b010, 16'd100, 16'hFFFB, 1'b0, 1'b0);
        @(negedge clk);
        chk("c7_abs_b", out_r, 16'd5);
        @(negedge clk);
        send(3'b111, 16'hFFF0, 16'd50, 1'b0, 1'b0);
        @(negedge clk);
        chk("c8_abs_a", out_r, 16'd16);
        chk("c8_sticky", 16'(sticky_ovf), 16'h0);
        @(negedge clk);

        // acc = 3, then reset during an overflowing EXEC
        send(3'b000, 16'd1, 16'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk("c9_acc", acc, 16'd3);
        @(negedge clk);
        send(3'b001, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("c10_rst_acc", acc, 16'h0);
        chk("c10_rst_valid", 16'(out_valid), 16'h0);
        chk("c10_rst_sticky", 16'(sticky_ovf), 16'h0);
        chk("c10_rst_ready", 16'(in_ready), 16'h0);
        chk("c10_rst_out_r", out_r, 16'h0);
        rst = 1'b0;
        #1;
        chk("c10_post_ready", 16'(in_ready), 16'h1);
        @(negedge clk);
        @(negedge clk);
        chk("c10_still_idle", 16'(out_valid), 16'h0);

        // Clear coincident with overflow capture
        send(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("c11_sticky_win", 16'(sticky_ovf), 16'h1);
        chk("c11_out_r", out_r, SAT ? 16'h7FFF : 16'h8000);
        chk("c11_acc", acc, 16'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
